// File: rtl/uart_sample_rx.sv
// uart_sample_rx: 8N1 receiver that reassembles 3-byte big-endian frames into 22-bit samples.
// Latency: byte_dv 1 clk after the stop-bit centre sample; sample_dv 1 clk after the last byte_dv.
// Backpressure: none; pulses are one cycle wide and must be consumed when they occur.
// Optional build macro UART_SAMPLE_RX_PARITY_EN switches the byte format to 8E1.
module uart_sample_rx #(
  parameter int CLKS_PER_BIT = 217,
  parameter int TIMEOUT_CLKS = 4340
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_serial,
  output logic        byte_dv,
  output logic [7:0]  byte_data,
  output logic        sample_dv,
  output logic [21:0] sample_data,
  output logic        frame_err,
  output logic        sync_err,
  output logic        rx_active
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_SAMPLE_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_CLEANUP
  } rx_state_t;

  typedef enum logic [1:0] {A0, A1, A2} asm_state_t;

  logic             rx_meta;
  logic             rxs;
  rx_state_t        rx_state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             armed;
  logic             stop_ok;
`ifdef UART_SAMPLE_RX_PARITY_EN
  logic             par_ok;
`endif

  asm_state_t       asm_state;
  logic [TO_W-1:0]  idle_cnt;
  logic [5:0]       hi_q;
  logic [7:0]       mid_q;

  // Byte is accepted only if the stop bit is high (and parity matched when enabled).
`ifdef UART_SAMPLE_RX_PARITY_EN
  assign stop_ok = rxs & par_ok;
`else
  assign stop_ok = rxs;
`endif

  // Two-flop synchroniser for the asynchronous line; idles high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rxs     <= rx_meta;
    end
  end

  // Receive FSM: start validation at mid-bit, then one sample per bit period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state  <= S_IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      armed     <= 1'b1;
      byte_dv   <= 1'b0;
      byte_data <= '0;
      frame_err <= 1'b0;
      rx_active <= 1'b0;
`ifdef UART_SAMPLE_RX_PARITY_EN
      par_ok    <= 1'b0;
`endif
    end else begin
      byte_dv   <= 1'b0;
      frame_err <= 1'b0;
      case (rx_state)
        S_IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
          // After a framing error the line must go high before a new start is trusted.
          if (!armed) begin
            if (rxs) armed <= 1'b1;
          end else if (!rxs) begin
            rx_state <= S_START;
          end
        end
        S_START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            if (!rxs) begin
              rx_state  <= S_DATA;
              rx_active <= 1'b1;
            end else begin
              rx_state <= S_IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt        <= '0;
            shift[bit_idx] <= rxs;
            if (bit_idx == 3'd7) begin
`ifdef UART_SAMPLE_RX_PARITY_EN
              rx_state <= S_PARITY;
`else
              rx_state <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`ifdef UART_SAMPLE_RX_PARITY_EN
        S_PARITY: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt  <= '0;
            par_ok   <= (rxs == ^shift);
            rx_state <= S_STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt   <= '0;
            rx_active <= 1'b0;
            rx_state  <= S_CLEANUP;
            if (stop_ok) begin
              byte_data <= shift;
              byte_dv   <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              armed     <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          rx_state <= S_IDLE;
        end
      endcase
    end
  end

  // Frame assembler: sync check on the first byte, inter-byte timeout drops partial frames.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      asm_state   <= A0;
      idle_cnt    <= '0;
      hi_q        <= '0;
      mid_q       <= '0;
      sample_dv   <= 1'b0;
      sample_data <= '0;
      sync_err    <= 1'b0;
    end else begin
      sample_dv <= 1'b0;
      sync_err  <= 1'b0;
      if (frame_err) begin
        asm_state <= A0;
        idle_cnt  <= '0;
      end else if (byte_dv) begin
        idle_cnt <= '0;
        case (asm_state)
          A0: begin
            if (byte_data[7:6] != 2'b00) begin
              sync_err <= 1'b1;
            end else begin
              hi_q      <= byte_data[5:0];
              asm_state <= A1;
            end
          end
          A1: begin
            mid_q     <= byte_data;
            asm_state <= A2;
          end
          default: begin
            sample_data <= {hi_q, mid_q, byte_data};
            sample_dv   <= 1'b1;
            asm_state   <= A0;
          end
        endcase
      end else if (asm_state != A0) begin
        if (idle_cnt == TO_LAST) begin
          idle_cnt  <= '0;
          asm_state <= A0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_sample_rx.sv
// Directed bench for uart_sample_rx: scoreboard queues of expected bytes and samples,
// popped and compared by a monitor on each byte_dv / sample_dv pulse.
module tb_uart_sample_rx;

  localparam int CPB = 217;
  localparam int TO  = 4340;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_serial = 1'b1;
  logic        byte_dv;
  logic [7:0]  byte_data;
  logic        sample_dv;
  logic [21:0] sample_data;
  logic        frame_err;
  logic        sync_err;
  logic        rx_active;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_bytes[$];
  logic [21:0] exp_samples[$];
  int exp_frame_err = 0;
  int exp_sync_err  = 0;
  int got_frame_err = 0;
  int got_sync_err  = 0;
  logic glitch_win  = 1'b0;
  int glitch_active = 0;
  logic prev_byte_dv = 1'b0;
  logic prev_frame_err = 1'b0;
  logic prev_sync_err = 1'b0;
  logic prev_sample_dv = 1'b0;

  uart_sample_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
    .clk(clk), .reset_n(reset_n), .rx_serial(rx_serial),
    .byte_dv(byte_dv), .byte_data(byte_data),
    .sample_dv(sample_dv), .sample_data(sample_data),
    .frame_err(frame_err), .sync_err(sync_err), .rx_active(rx_active)
  );

  always #5 clk = ~clk;

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int idle_bits);
    rx_serial = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      wait_clks(CPB);
    end
`ifdef UART_SAMPLE_RX_PARITY_EN
    rx_serial = ^b;
    wait_clks(CPB);
`endif
    rx_serial = stop_bit;
    wait_clks(CPB);
    rx_serial = 1'b1;
    wait_clks(CPB * idle_bits);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each output pulse, counts error pulses.
  always @(negedge clk) begin
    if (reset_n) begin
      if (glitch_win && rx_active) glitch_active++;
      if (byte_dv) begin
        if (exp_bytes.size() == 0) check("byte_dv_unexpected", {24'd0, byte_data}, 32'hFFFF_FFFF);
        else check("byte_data", {24'd0, byte_data}, {24'd0, exp_bytes.pop_front()});
        check("byte_dv_width", {31'd0, prev_byte_dv}, 32'd0);
      end
      if (sample_dv) begin
        if (exp_samples.size() == 0) check("sample_dv_unexpected", {10'd0, sample_data}, 32'hFFFF_FFFF);
        else check("sample_data", {10'd0, sample_data}, {10'd0, exp_samples.pop_front()});
        check("sample_after_byte", {31'd0, prev_byte_dv}, 32'd1);
        check("sample_dv_width", {31'd0, prev_sample_dv}, 32'd0);
      end
      if (frame_err) begin
        got_frame_err++;
        check("frame_err_width", {31'd0, prev_frame_err}, 32'd0);
      end
      if (sync_err) begin
        got_sync_err++;
        check("sync_err_width", {31'd0, prev_sync_err}, 32'd0);
      end
    end
    prev_byte_dv   = reset_n & byte_dv;
    prev_sample_dv = reset_n & sample_dv;
    prev_frame_err = reset_n & frame_err;
    prev_sync_err  = reset_n & sync_err;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_dv"},     {31'd0, byte_dv},     32'd0);
    check({tag, "_byte_data"},   {24'd0, byte_data},   32'd0);
    check({tag, "_sample_dv"},   {31'd0, sample_dv},   32'd0);
    check({tag, "_sample_data"}, {10'd0, sample_data}, 32'd0);
    check({tag, "_frame_err"},   {31'd0, frame_err},   32'd0);
    check({tag, "_sync_err"},    {31'd0, sync_err},    32'd0);
    check({tag, "_rx_active"},   {31'd0, rx_active},   32'd0);
  endtask

  initial begin
    // Reset state
    wait_clks(3);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    wait_clks(CPB);

    // Basic frame 0x03 0xAB 0xCD
    exp_bytes.push_back(8'h03); exp_bytes.push_back(8'hAB); exp_bytes.push_back(8'hCD);
    exp_samples.push_back(22'h03ABCD);
    send_byte(8'h03, 1'b1, 1);
    send_byte(8'hAB, 1'b1, 1);
    send_byte(8'hCD, 1'b1, 1);
    check("basic_sample_hold", {10'd0, sample_data}, 32'h0003ABCD);
    check("basic_errs", got_frame_err + got_sync_err, 0);

    // Short glitch on idle line must not start a byte
    glitch_win = 1'b1;
    rx_serial = 1'b0;
    wait_clks(50);
    rx_serial = 1'b1;
    wait_clks(CPB * 2);
    glitch_win = 1'b0;
    check("glitch_rx_active", glitch_active, 0);
    check("glitch_no_byte", exp_bytes.size(), 0);

    // Framing error, then a clean frame
    exp_frame_err++;
    send_byte(8'h55, 1'b0, 1);
    check("frame_err_count", got_frame_err, exp_frame_err);
    exp_bytes.push_back(8'h00); exp_bytes.push_back(8'h12); exp_bytes.push_back(8'h34);
    exp_samples.push_back(22'h001234);
    send_byte(8'h00, 1'b1, 1);
    send_byte(8'h12, 1'b1, 1);
    send_byte(8'h34, 1'b1, 1);

    // Sync error on first byte, then max-value frame
    exp_sync_err++;
    exp_bytes.push_back(8'hC1);
    send_byte(8'hC1, 1'b1, 1);
    check("sync_err_count", got_sync_err, exp_sync_err);
    exp_bytes.push_back(8'h3F); exp_bytes.push_back(8'hFF); exp_bytes.push_back(8'hFF);
    exp_samples.push_back(22'h3FFFFF);
    send_byte(8'h3F, 1'b1, 1);
    send_byte(8'hFF, 1'b1, 1);
    send_byte(8'hFF, 1'b1, 1);

    // Inter-byte timeout drops the partial frame
    exp_bytes.push_back(8'h01); exp_bytes.push_back(8'h02);
    send_byte(8'h01, 1'b1, 1);
    send_byte(8'h02, 1'b1, 0);
    wait_clks(TO + 700);
    exp_bytes.push_back(8'h02); exp_bytes.push_back(8'h03); exp_bytes.push_back(8'h04);
    exp_samples.push_back(22'h020304);
    send_byte(8'h02, 1'b1, 1);
    send_byte(8'h03, 1'b1, 1);
    send_byte(8'h04, 1'b1, 1);
    check("timeout_sample", {10'd0, sample_data}, 32'h00020304);
    check("timeout_queue", exp_samples.size(), 0);

    // Reset during bit 4 of the second byte
    exp_bytes.push_back(8'h01);
    send_byte(8'h01, 1'b1, 1);
    rx_serial = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 4; i++) begin
      rx_serial = i[0];
      wait_clks(CPB);
    end
    rx_serial = 1'b1;
    wait_clks(CPB / 2);
    check("mid_byte_active", {31'd0, rx_active}, 32'd1);
    reset_n = 1'b0;
    wait_clks(2);
    check_reset_outputs("midreset");
    wait_clks(10);
    reset_n = 1'b1;
    wait_clks(CPB * 2);
    exp_bytes.push_back(8'h10); exp_bytes.push_back(8'h20); exp_bytes.push_back(8'h30);
    exp_samples.push_back(22'h102030);
    send_byte(8'h10, 1'b1, 1);
    send_byte(8'h20, 1'b1, 1);
    send_byte(8'h30, 1'b1, 2);

    // Final scoreboard state
    check("final_sample", {10'd0, sample_data}, 32'h00102030);
    check("final_bytes_left", exp_bytes.size(), 0);
    check("final_samples_left", exp_samples.size(), 0);
    check("final_frame_err", got_frame_err, exp_frame_err);
    check("final_sync_err", got_sync_err, exp_sync_err);
    check("final_rx_active", {31'd0, rx_active}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
